keystream_scheduler: RTL

- Sequences one chaos-based encryption pass: advances the three chaotic map generators, waits for all three outputs, and waits out the 2-cycle mixer pipeline.
- Captures the mixer's 8-bit keystream byte, discards a warm-up run, then XORs each keystream byte with one plaintext pixel.
- Sits between the pixel source/sink and the generator + mixer datapath; one keystream byte per pixel, pixel order preserved.

---
 rtl/keystream_scheduler.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/keystream_scheduler.sv
// keystream_scheduler
//   Sequences one chaos-based encryption pass per pixel: pulses the three
//   chaotic map generators, collects their per-map valids, waits out the
//   mixer pipeline, captures the keystream byte and XORs it with one
//   plaintext pixel. The first WARMUP keystream bytes of a frame are dropped.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start, abort    frame start pulse (IDLE/DONE only); abort level -> IDLE
//   gen_step        one-cycle advance pulse to all three maps
//   gen_valid[2:0]  per-map output valid, held until the next gen_step
//   mix_ks[7:0]     low byte of mixer output
//   pix_in*         plaintext pixel source handshake
//   ct_out/ct_*     ciphertext pixel sink handshake (ct_valid held to ct_ready)
//   busy            high outside IDLE/DONE
//   done            one-cycle pulse after the last pixel of a frame is handed off
//   err             sticky generator timeout, cleared by start or rst
//   pix_count       pixels handed off in the current frame
module keystream_scheduler #(
  parameter int NUM_PIXELS  = 65536,
  parameter int WARMUP      = 16,
  parameter int MIX_LAT     = 2,
  parameter int GEN_TIMEOUT = 255,
  parameter int CNT_W       = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             gen_step,
  input  logic [2:0]       gen_valid,
  input  logic [7:0]       mix_ks,
  input  logic [7:0]       pix_in,
  input  logic             pix_in_valid,
  output logic             pix_in_ready,
  output logic [7:0]       ct_out,
  output logic             ct_valid,
  input  logic             ct_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] pix_count
);

  localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int TW = $clog2(GEN_TIMEOUT + 1);

  localparam logic [WW-1:0]    WARM_INIT = WW'(WARMUP);
  localparam logic [TW-1:0]    TO_LAST   = TW'(GEN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_WAIT, S_MIX, S_XFER, S_OUT, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]         vlat;       // sticky per-map valids for the current step
  logic [TW-1:0]      tcnt;       // WAIT_GEN cycles spent on the current step
  logic [WW-1:0]      warm;       // keystream bytes still to discard
  logic [MIX_LAT-1:0] vld_pipe;   // one-hot walk through the mixer latency
  logic [7:0]         ks;

  logic all_vld, to_hit, mix_last, last_pix;

  // Current-cycle valids count so MIX starts the edge after the last bit lands.
  assign all_vld  = &(vlat | gen_valid);
  assign to_hit   = (tcnt == TO_LAST);
  assign mix_last = vld_pipe[MIX_LAT-1];
  assign last_pix = (pix_count == PIX_LAST);

  assign gen_step     = (state_q == S_STEP);
  // Gated by abort so a pixel offered in the aborting cycle is not consumed.
  assign pix_in_ready = (state_q == S_XFER) && !abort;
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_STEP;
      S_STEP:         state_d = S_WAIT;
      S_WAIT: begin
        if (all_vld)     state_d = S_MIX;
        else if (to_hit) state_d = S_IDLE;
      end
      S_MIX:          if (mix_last) state_d = (warm != '0) ? S_STEP : S_XFER;
      S_XFER:         if (pix_in_valid) state_d = S_OUT;
      S_OUT:          if (ct_ready) state_d = last_pix ? S_DONE : S_STEP;
      default:        state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vlat      <= '0;
      tcnt      <= '0;
      warm      <= '0;
      vld_pipe  <= '0;
      ks        <= '0;
      ct_out    <= '0;
      ct_valid  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pix_count <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // pix_count and ct_out stay put for post-mortem inspection.
        ct_valid <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start) begin
              pix_count <= '0;
              err       <= 1'b0;
              warm      <= WARM_INIT;
            end
          end
          S_STEP: begin
            // Valids seen here belong to the previous iteration.
            vlat <= '0;
            tcnt <= '0;
          end
          S_WAIT: begin
            vlat <= vlat | gen_valid;
            tcnt <= tcnt + 1'b1;
            if (all_vld)     vld_pipe <= MIX_LAT'(1);
            else if (to_hit) err      <= 1'b1;
          end
          S_MIX: begin
            vld_pipe <= vld_pipe << 1;
            if (mix_last) begin
              ks <= mix_ks;
              if (warm != '0) warm <= warm - 1'b1;
            end
          end
          S_XFER: begin
            if (pix_in_valid) begin
              ct_out   <= pix_in ^ ks;
              ct_valid <= 1'b1;
            end
          end
          S_OUT: begin
            if (ct_ready) begin
              ct_valid  <= 1'b0;
              pix_count <= pix_count + 1'b1;
              if (last_pix) done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
